// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flags.
// Imported by alu_seq and alu_seq_mul.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_AND  = 3'b001,
    OP_NOT  = 3'b010,
    OP_PASS = 3'b011,
    OP_SUB  = 3'b100,
    OP_XOR  = 3'b101,
    OP_SHL  = 3'b110,
    OP_MUL  = 3'b111
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
    logic v;
  } flags_t;

  // Reset flags: result 0 reads as zero.
  localparam flags_t FLAGS_RST = 4'b0100;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier, one iteration per cycle, WIDTH cycles.
// Ports: Clk, Reset (async low), start/a/b in, done/prod out.
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      cnt_d    = CNT_W'(WIDTH);
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  // done marks the cycle whose edge performs the last iteration;
  // prod is the post-iteration accumulator so the top can load it
  // on that same edge.
  assign done = (cnt_q == CNT_W'(1));
  assign prod = acc_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked registered ALU with NZP/V flags; optional iterative MUL
// enabled by macro ALU_SEQ_MUL_EN (else op 111 returns 0 in one cycle).
// Ports: Clk, Reset(async low), in_valid/in_ready/op/A/B,
//        out_valid/out_ready/result/n_flag/z_flag/p_flag/v_flag.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n_flag,
  output logic             z_flag,
  output logic             p_flag,
  output logic             v_flag
);

  localparam int  CNT_W = $clog2(WIDTH) + 1;
  localparam int  SH_W  = CNT_W - 1;
  localparam bit  POW2  = (WIDTH & (WIDTH - 1)) == 0;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] sum, diff, shl_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic [SH_W-1:0]  sh_amt;

  function automatic flags_t mk_flags(
    input logic [WIDTH-1:0] r,
    input logic             v
  );
    flags_t f;
    f.n = r[WIDTH-1];
    f.z = (r == '0);
    f.p = !r[WIDTH-1] && (r != '0);
    f.v = v;
    return f;
  endfunction

  assign in_ready = (state_q == IDLE) &&
                    (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign sum    = A + B;
  assign diff   = A - B;
  assign sh_amt = B[SH_W-1:0];

  // Only a non-power-of-two WIDTH can see an amount >= WIDTH.
  if (POW2) begin : g_shl_p2
    assign shl_res = A << sh_amt;
  end else begin : g_shl_np2
    assign shl_res = (32'(sh_amt) >= WIDTH) ? '0 : (A << sh_amt);
  end

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    unique case (alu_op_e'(op))
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                  (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_NOT:  alu_res = ~A;
      OP_PASS: alu_res = A;
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                  (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_XOR:  alu_res = A ^ B;
      OP_SHL:  alu_res = shl_res;
      OP_MUL:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign is_mul    = (alu_op_e'(op) == OP_MUL);
  assign mul_start = accept && is_mul;

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .Clk   (Clk),
    .Reset (Reset),
    .start (mul_start),
    .a     (A),
    .b     (B),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = MULT;
          end else begin
            result_d    = alu_res;
            flags_d     = mk_flags(alu_res, alu_v);
            out_valid_d = 1'b1;
          end
        end
      end
      MULT: begin
`ifdef ALU_SEQ_MUL_EN
        // Output register was empty or drained on entry.
        if (mul_done) begin
          state_d     = IDLE;
          result_d    = mul_prod;
          flags_d     = mk_flags(mul_prod, 1'b0);
          out_valid_d = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= FLAGS_RST;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign n_flag    = flags_q.n;
  assign z_flag    = flags_q.z;
  assign p_flag    = flags_q.p;
  assign v_flag    = flags_q.v;

endmodule
